// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serializer slice.
// State encoding and counter-width helper used by serializer and bit_timer.
package serializer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} ser_state_t;

    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled, held at zero otherwise.
// tick marks the last clock of a bit period, first marks its first clock.
module bit_timer
    import serializer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic first
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt_q;
    logic [W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick  = (div_cnt_q == LAST);
    assign first = (div_cnt_q == '0);

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial shifter with valid/ready input and programmable bit period.
// Optional even parity bit after the data word: define SERIALIZER_PARITY_EN.
module serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdo,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    localparam int BW = cnt_w(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tick, first, xfer;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign xfer = in_valid & in_ready;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk   (clk),
        .clr   (clr),
        .en    (busy),
        .tick  (tick),
        .first (first)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d   = S_SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    // Zero-fill so sdo naturally idles low behind the data.
                    shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
`ifdef SERIALIZER_PARITY_EN
                if (tick) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        sdo = 1'b0;
        case (state_q)
            S_SHIFT:  sdo = shreg_q[OUT_IDX];
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: sdo = parity_q;
`endif
            default:  sdo = 1'b0;
        endcase
    end

    assign in_ready = (state_q == S_IDLE) & ~clr;
    assign busy     = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign done     = (state_q == S_DONE);
    assign bit_stb  = busy & first;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: LSB-first and MSB-first instances share stimulus.
module tb_serializer;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int FRAME = NBITS * DIV;

    typedef struct {
        logic [7:0] d;
        logic [7:0] rev;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rdy0, sdo0, stb0, busy0, done0;
    logic       rdy1, sdo1, stb1, busy1, done1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serializer #(.WIDTH(WIDTH), .DIV(DIV), .MSB_FIRST(0)) dut0 (
        .clk(clk), .clr(clr), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy0), .sdo(sdo0), .bit_stb(stb0), .busy(busy0), .done(done0)
    );

    serializer #(.WIDTH(WIDTH), .DIV(DIV), .MSB_FIRST(1)) dut1 (
        .clk(clk), .clr(clr), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy1), .sdo(sdo1), .bit_stb(stb1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // Called at the negedge of the first cycle after the transfer edge.
    task automatic check_frame(input logic [7:0] d, input logic [7:0] rev, input logic par);
        int   idx;
        logic e0, e1;
        for (int c = 1; c <= FRAME; c++) begin
            idx = (c - 1) / DIV;
            e0  = (idx < WIDTH) ? d[idx]   : par;
            e1  = (idx < WIDTH) ? rev[idx] : par;
            chk("sdo_lsb", sdo0, e0);
            chk("sdo_msb", sdo1, e1);
            chk("bit_stb", stb0, ((c - 1) % DIV) == 0);
            chk("busy", busy0, 1);
            chk("in_ready_busy", rdy0, 0);
            chk("done_early", done0 | done1, 0);
            @(negedge clk);
        end
        chk("done_lsb", done0, 1);
        chk("done_msb", done1, 1);
        chk("sdo_done", sdo0 | sdo1, 0);
        chk("busy_done", busy0, 0);
        chk("in_ready_done", rdy0, 0);
        @(negedge clk);
        chk("done_pulse_end", done0, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] rev, input logic par,
                        input bit hold);
        data_in  = d;
        in_valid = 1'b1;
        chk("in_ready_pre", rdy0 & rdy1, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        check_frame(d, rev, par);
    endtask

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{d: 8'h01, rev: 8'h80, par: 1'b1};
        tbl[1] = '{d: 8'hA5, rev: 8'hA5, par: 1'b0};
        tbl[2] = '{d: 8'hC4, rev: 8'h23, par: 1'b1};
        tbl[3] = '{d: 8'h3C, rev: 8'h3C, par: 1'b0};
        tbl[4] = '{d: 8'h07, rev: 8'hE0, par: 1'b1};

        // Reset held for 3 clocks
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_sdo", sdo0 | sdo1, 0);
            chk("rst_stb", stb0 | stb1, 0);
            chk("rst_busy", busy0 | busy1, 0);
            chk("rst_done", done0 | done1, 0);
            chk("rst_in_ready", rdy0 | rdy1, 0);
        end
        clr = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", rdy0 & rdy1, 1);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d, tbl[i].rev, tbl[i].par, 1'b0);
            chk("in_ready_idle", rdy0, 1);
        end

        // Back-to-back with in_valid held: second word taken 1 clk after done
        send(8'hFF, 8'hFF, 1'b0, 1'b1);
        send(8'h00, 8'h00, 1'b0, 1'b0);

        // Abort during bit 3 of 8'hAA
        data_in  = 8'hAA;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("abort_pre_sdo", sdo0, 1);
        chk("abort_pre_busy", busy0, 1);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy0 | busy1, 0);
        chk("abort_sdo", sdo0 | sdo1, 0);
        chk("abort_in_ready", rdy0, 0);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", done0 | done1, 0);
            @(negedge clk);
        end
        chk("abort_in_ready_after", rdy0, 1);
        send(8'h0F, 8'hF0, 1'b0, 1'b0);

        // clr together with in_valid: nothing captured
        data_in  = 8'h55;
        in_valid = 1'b1;
        clr      = 1'b1;
        @(negedge clk);
        chk("clr_valid_busy", busy0 | busy1, 0);
        chk("clr_valid_in_ready", rdy0, 0);
        clr      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_valid_idle", busy0 | busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
